// File: rtl/fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_if
// Bundles the fetch-stage control inputs, the instruction-memory port, the
// IF/ID register outputs and the performance counters of fetch_ctrl.
//   slave  : the fetch_ctrl side (consumes stall/branch/resume/imem_data,
//            drives imem_addr, IF/ID, halted and the counters)
//   master : the environment side (pipeline, instruction memory, bench)
// Parameters: ADDR_W byte-address width, INST_W instruction width.
// ---------------------------------------------------------------------------
interface fetch_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int INST_W = 16
);
  logic              stall;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              resume;
  logic [INST_W-1:0] imem_data;
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] ifid_inst;
  logic [ADDR_W-1:0] ifid_pc;
  logic              ifid_valid;
  logic              halted;
  logic [15:0]       fetch_cnt;
  logic [15:0]       stall_cnt;

  modport slave (
    input  stall, branch_taken, branch_target, resume, imem_data,
    output imem_addr, ifid_inst, ifid_pc, ifid_valid, halted,
           fetch_cnt, stall_cnt
  );

  modport master (
    output stall, branch_taken, branch_target, resume, imem_data,
    input  imem_addr, ifid_inst, ifid_pc, ifid_valid, halted,
           fetch_cnt, stall_cnt
  );
endinterface

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch stage: owns the PC, drives the instruction memory
// address, and fills the IF/ID register. A three-state FSM (IDLE, RUN, HALT)
// sequences start-up, normal fetch and halting on the HALT_OP opcode.
//
// Ports:
//   i_clk  : clock, all state on the rising edge
//   i_rst  : asynchronous reset, active-low
//   bus    : fetch_ctrl_if.slave
//            in : stall, branch_taken, branch_target, resume, imem_data
//            out: imem_addr (= PC), ifid_inst, ifid_pc, ifid_valid,
//                 halted, fetch_cnt, stall_cnt
//
// Build option: define FETCH_PERF_CNT_EN to enable the fetch/stall
// performance counters; otherwise both counter outputs read 16'h0000.
// ---------------------------------------------------------------------------
module fetch_ctrl #(
  parameter int                ADDR_W   = 8,
  parameter int                INST_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
  parameter logic [3:0]        HALT_OP  = 4'hF
) (
  input logic          i_clk,
  input logic          i_rst,
  fetch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc_p0;
  logic [INST_W-1:0] r_ifid_inst_p1;
  logic [ADDR_W-1:0] r_ifid_pc_p1;
  logic              r_vld_p1;
  logic              r_halted;

  logic              w_is_halt;

  // Next sequential instruction; wraps naturally at 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] f_pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(2);
  endfunction

  // Instructions are halfword aligned, so the redirect LSB is forced to 0.
  function automatic logic [ADDR_W-1:0] f_pc_align(input logic [ADDR_W-1:0] tgt);
    return tgt & ~ADDR_W'(1);
  endfunction

  assign w_is_halt = (bus.imem_data[INST_W-1 -: 4] == HALT_OP);

  // ---- stage p0: PC drives the instruction memory -------------------------
  assign bus.imem_addr = r_pc_p0;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state        <= S_IDLE;
      r_pc_p0        <= RESET_PC;
      r_ifid_inst_p1 <= '0;
      r_ifid_pc_p1   <= '0;
      r_vld_p1       <= 1'b0;
      r_halted       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_RUN;
        end

        S_RUN: begin
          if (bus.branch_taken) begin
            r_pc_p0        <= f_pc_align(bus.branch_target);
            r_ifid_inst_p1 <= '0;
            r_vld_p1       <= 1'b0;
          end else if (!bus.stall) begin
            r_ifid_inst_p1 <= bus.imem_data;
            r_ifid_pc_p1   <= r_pc_p0;
            r_vld_p1       <= 1'b1;
            if (w_is_halt) begin
              // PC stays on the halt word so resume can step past it.
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end else begin
              r_pc_p0 <= f_pc_inc(r_pc_p0);
            end
          end
        end

        S_HALT: begin
          r_vld_p1 <= 1'b0;
          if (bus.branch_taken) begin
            // The halt came from a wrong path; the redirect cancels it.
            r_pc_p0        <= f_pc_align(bus.branch_target);
            r_ifid_inst_p1 <= '0;
            r_state        <= S_RUN;
            r_halted       <= 1'b0;
          end else if (bus.resume) begin
            r_pc_p0  <= f_pc_inc(r_pc_p0);
            r_state  <= S_RUN;
            r_halted <= 1'b0;
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  // ---- stage p1: IF/ID register outputs -----------------------------------
  assign bus.ifid_inst  = r_ifid_inst_p1;
  assign bus.ifid_pc    = r_ifid_pc_p1;
  assign bus.ifid_valid = r_vld_p1;
  assign bus.halted     = r_halted;

`ifdef FETCH_PERF_CNT_EN
  logic        w_fetch_ld;
  logic        w_stall_cyc;
  logic [15:0] r_fetch_cnt;
  logic [15:0] r_stall_cnt;

  // A load happens on every unstalled, unredirected RUN edge (halt word too).
  assign w_fetch_ld  = (r_state == S_RUN) && !bus.branch_taken && !bus.stall;
  assign w_stall_cyc = (r_state == S_RUN) && !bus.branch_taken &&  bus.stall;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_fetch_ld)  r_fetch_cnt <= r_fetch_cnt + 16'd1;
      if (w_stall_cyc) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign bus.fetch_cnt = r_fetch_cnt;
  assign bus.stall_cnt = r_stall_cnt;
`else
  assign bus.fetch_cnt = 16'h0000;
  assign bus.stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
// Directed vector table for start-up, stall, branch and halt/resume, hand
// sequences for async reset and RESET_PC wrap, then randomized traffic
// against a behavioural fetch model.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;
  localparam int AW = 8;
  localparam int IW = 16;

`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_ctrl_if #(.ADDR_W(AW), .INST_W(IW)) bus ();
  fetch_ctrl_if #(.ADDR_W(AW), .INST_W(IW)) bus_fc ();

  logic [15:0] mem [0:127];
  assign bus.imem_data    = mem[bus.imem_addr[7:1]];
  assign bus_fc.imem_data = mem[bus_fc.imem_addr[7:1]];

  fetch_ctrl #(.ADDR_W(AW), .INST_W(IW), .RESET_PC(8'h00), .HALT_OP(4'hF)) u_dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  fetch_ctrl #(.ADDR_W(AW), .INST_W(IW), .RESET_PC(8'hFC), .HALT_OP(4'hF)) u_dut_fc (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus_fc)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_RUN, M_HALT} mmode_t;
  mmode_t      m_mode;
  logic [7:0]  m_pc, m_ifpc;
  logic [15:0] m_inst, m_fcnt, m_scnt;
  bit          m_valid;

  task automatic model_reset(input logic [7:0] pc0);
    m_mode = M_IDLE; m_pc = pc0; m_ifpc = 8'h00; m_inst = 16'h0000;
    m_valid = 1'b0; m_fcnt = 16'h0; m_scnt = 16'h0;
  endtask

  task automatic model_step(input bit st, input bit br, input logic [7:0] tgt, input bit res);
    logic [15:0] word;
    word = mem[m_pc / 2];
    case (m_mode)
      M_IDLE: m_mode = M_RUN;
      M_RUN: begin
        if (br) begin
          m_pc = 8'((tgt / 2) * 2); m_valid = 1'b0; m_inst = 16'h0;
        end else if (st) begin
          m_scnt = m_scnt + 16'd1;
        end else begin
          m_inst = word; m_ifpc = m_pc; m_valid = 1'b1; m_fcnt = m_fcnt + 16'd1;
          if (word[15:12] == 4'hF) m_mode = M_HALT;
          else m_pc = 8'((int'(m_pc) + 2) % 256);
        end
      end
      M_HALT: begin
        m_valid = 1'b0;
        if (br) begin
          m_pc = 8'((tgt / 2) * 2); m_inst = 16'h0; m_mode = M_RUN;
        end else if (res) begin
          m_pc = 8'((int'(m_pc) + 2) % 256); m_mode = M_RUN;
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic check_model(input string tag);
    check({tag, ".addr"},   bus.imem_addr,  m_pc);
    check({tag, ".valid"},  bus.ifid_valid, m_valid);
    check({tag, ".ifpc"},   bus.ifid_pc,    m_ifpc);
    check({tag, ".inst"},   bus.ifid_inst,  m_inst);
    check({tag, ".halted"}, bus.halted,     (m_mode == M_HALT));
    check({tag, ".fcnt"},   bus.fetch_cnt,  PERF ? m_fcnt : 16'h0);
    check({tag, ".scnt"},   bus.stall_cnt,  PERF ? m_scnt : 16'h0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          st;
    bit          br;
    logic [7:0]  tgt;
    bit          res;
    logic [7:0]  addr;
    bit          valid;
    bit          chk;     // compare ifid_pc/ifid_inst on this row
    logic [7:0]  ifpc;
    logic [15:0] inst;
    bit          halted;
  } vec_t;

  vec_t vt [13];

  task automatic drive(input bit st, input bit br, input logic [7:0] tgt, input bit res);
    bus.stall = st; bus.branch_taken = br; bus.branch_target = tgt; bus.resume = res;
  endtask

  initial begin
    vt[0]  = '{0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h00, 16'h0000, 0};
    vt[1]  = '{0, 0, 8'h00, 0, 8'h02, 1, 1, 8'h00, 16'h1000, 0};
    vt[2]  = '{0, 0, 8'h00, 0, 8'h04, 1, 1, 8'h02, 16'h1002, 0};
    vt[3]  = '{1, 0, 8'h00, 0, 8'h04, 1, 1, 8'h02, 16'h1002, 0};
    vt[4]  = '{1, 0, 8'h00, 0, 8'h04, 1, 1, 8'h02, 16'h1002, 0};
    vt[5]  = '{0, 0, 8'h00, 0, 8'h06, 1, 1, 8'h04, 16'h1004, 0};
    vt[6]  = '{0, 1, 8'h3B, 0, 8'h3A, 0, 0, 8'h00, 16'h0000, 0};
    vt[7]  = '{0, 0, 8'h00, 0, 8'h3C, 1, 1, 8'h3A, 16'h103A, 0};
    vt[8]  = '{1, 1, 8'h08, 0, 8'h08, 0, 0, 8'h00, 16'h0000, 0};
    vt[9]  = '{0, 0, 8'h00, 0, 8'h08, 1, 1, 8'h08, 16'hF000, 1};
    vt[10] = '{1, 0, 8'h00, 0, 8'h08, 0, 0, 8'h00, 16'h0000, 1};
    vt[11] = '{0, 0, 8'h00, 1, 8'h0A, 0, 0, 8'h00, 16'h0000, 0};
    vt[12] = '{0, 0, 8'h00, 0, 8'h0C, 1, 1, 8'h0A, 16'h100A, 0};

    for (int i = 0; i < 128; i++) mem[i] = 16'h1000 + 16'(2 * i);
    mem[4] = 16'hF000;

    bus_fc.stall = 1'b0; bus_fc.branch_taken = 1'b0;
    bus_fc.branch_target = 8'h00; bus_fc.resume = 1'b0;
    drive(0, 0, 8'h00, 0);

    // reset state, release at t=10
    rst_n = 1'b0;
    #8;
    check("rst.addr",   bus.imem_addr,  8'h00);
    check("rst.valid",  bus.ifid_valid, 1'b0);
    check("rst.inst",   bus.ifid_inst,  16'h0);
    check("rst.ifpc",   bus.ifid_pc,    8'h00);
    check("rst.halted", bus.halted,     1'b0);
    check("rst.fcnt",   bus.fetch_cnt,  16'h0);
    check("rst.scnt",   bus.stall_cnt,  16'h0);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(vt[i].st, vt[i].br, vt[i].tgt, vt[i].res);
      @(posedge clk); #1;
      check($sformatf("vec%0d.addr", i),   bus.imem_addr,  vt[i].addr);
      check($sformatf("vec%0d.valid", i),  bus.ifid_valid, vt[i].valid);
      check($sformatf("vec%0d.halted", i), bus.halted,     vt[i].halted);
      if (vt[i].chk) begin
        check($sformatf("vec%0d.ifpc", i), bus.ifid_pc,   vt[i].ifpc);
        check($sformatf("vec%0d.inst", i), bus.ifid_inst, vt[i].inst);
      end
    end
    check("vec.fcnt", bus.fetch_cnt, PERF ? 16'd6 : 16'd0);
    check("vec.scnt", bus.stall_cnt, PERF ? 16'd2 : 16'd0);

    // async reset while halted, between edges
    drive(0, 1, 8'h08, 0);
    @(posedge clk); #1;
    drive(0, 0, 8'h00, 0);
    @(posedge clk); #1;
    check("hrst.pre_halted", bus.halted, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("hrst.addr",    bus.imem_addr,    8'h00);
    check("hrst.halted",  bus.halted,       1'b0);
    check("hrst.valid",   bus.ifid_valid,   1'b0);
    check("hrst.inst",    bus.ifid_inst,    16'h0);
    check("hrst.fcnt",    bus.fetch_cnt,    16'h0);
    check("hrst.fc_addr", bus_fc.imem_addr, 8'hFC);
    #1 rst_n = 1'b1;

    // RESET_PC = FC wraps through 00
    @(posedge clk); #1; check("fc.e1", bus_fc.imem_addr, 8'hFC);
    @(posedge clk); #1; check("fc.e2", bus_fc.imem_addr, 8'hFE);
    @(posedge clk); #1; check("fc.e3", bus_fc.imem_addr, 8'h00);
    @(posedge clk); #1; check("fc.e4", bus_fc.imem_addr, 8'h02);
    check("fc.ifpc", bus_fc.ifid_pc, 8'h00);

    // randomized traffic against the model
    for (int i = 0; i < 128; i++) begin
      mem[i] = 16'($urandom);
      if ($urandom_range(0, 9) == 0) mem[i][15:12] = 4'hF;
      else if (mem[i][15:12] == 4'hF) mem[i][15:12] = 4'h3;
    end
    rst_n = 1'b0;
    drive(0, 0, 8'h00, 0);
    #2;
    model_reset(8'h00);
    check_model("rnd.rst");
    rst_n = 1'b1;

    for (int c = 0; c < 400; c++) begin
      bit st, br, res;
      logic [7:0] tgt;
      st  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 9) == 0);
      res = ($urandom_range(0, 2) == 0);
      tgt = 8'($urandom);
      drive(st, br, tgt, res);
      model_step(st, br, tgt, res);
      @(posedge clk); #1;
      check_model($sformatf("rnd%0d", c));
      if ($urandom_range(0, 79) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset(8'h00);
        check_model($sformatf("rnd%0d.arst", c));
        #1 rst_n = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
